// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the segment-pipelined adder.
// Provides the stage-count and configuration-check functions.
package addsub_pkg;

  typedef struct packed {
    logic co;
    logic z;
    logic v;
  } flags_t;

  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic bit seg_ok(input int width, input int seg);
    return (seg > 0) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/addsub_pipe_seg.sv
// addsub_seg: combinational SEG-bit carry-lookahead segment.
// Each carry is a flat generate/propagate sum of products.
module addsub_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb,
  output logic           zero
);
  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           pp;
  logic           acc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    pp   = 1'b0;
    acc  = 1'b0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s     = p ^ c[SEG-1:0];
  assign co    = c[SEG];
  assign c_msb = c[SEG-1];
  assign zero  = ~|s;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: WIDTH-bit add/sub, one SEG-bit segment per stage.
// Define ADDSUB_FLAGS_EN to build the z and v flag ports.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             z,
  output logic             v
`endif
);
  localparam int STAGES = stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH not a multiple of SEG");
  end

  logic stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_i, v_i, vld_q, c_q;
    logic [SEG-1:0]   seg_s;
    logic             seg_c, seg_m, seg_z;
`ifdef ADDSUB_FLAGS_EN
    logic             zr_i, z_q, m_q;
`endif

    // B is inverted once at entry; only the inverted copy travels.
    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = b ^ {WIDTH{sub}};
      assign c_i = sub;
      assign v_i = in_valid;
      assign s_i = '0;
`ifdef ADDSUB_FLAGS_EN
      assign zr_i = 1'b1;
`endif
    end else begin : g_tail
      assign a_i = g_stg[k-1].a_q;
      assign b_i = g_stg[k-1].b_q;
      assign c_i = g_stg[k-1].c_q;
      assign v_i = g_stg[k-1].vld_q;
      assign s_i = g_stg[k-1].s_q;
`ifdef ADDSUB_FLAGS_EN
      assign zr_i = g_stg[k-1].z_q;
`endif
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .a     (a_i[k*SEG +: SEG]),
      .b     (b_i[k*SEG +: SEG]),
      .ci    (c_i),
      .s     (seg_s),
      .co    (seg_c),
      .c_msb (seg_m),
      .zero  (seg_z)
    );

    always_comb begin
      s_n = s_i;
      s_n[k*SEG +: SEG] = seg_s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (!stall) begin
        vld_q <= v_i;
        c_q   <= seg_c;
        s_q   <= s_n;
        a_q   <= a_i;
        b_q   <= b_i;
      end
    end

`ifdef ADDSUB_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        z_q <= 1'b0;
        m_q <= 1'b0;
      end else if (!stall) begin
        z_q <= zr_i & seg_z;
        m_q <= seg_m;
      end
    end

    logic unused_stg;
    assign unused_stg = ^{a_q, b_q, s_i, m_q};
`else
    logic unused_stg;
    assign unused_stg = ^{a_q, b_q, s_i, seg_m, seg_z};
`endif
  end

  assign out_valid = g_stg[LAST].vld_q;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign s         = g_stg[LAST].s_q;

`ifdef ADDSUB_FLAGS_EN
  flags_t flg;

  assign flg.co = g_stg[LAST].c_q;
  assign flg.z  = g_stg[LAST].z_q;
  assign flg.v  = g_stg[LAST].c_q ^ g_stg[LAST].m_q;
  assign co     = flg.co;
  assign z      = flg.z;
  assign v      = flg.v;
`else
  assign co = g_stg[LAST].c_q;
`endif

endmodule
